// File: rtl/mem_scan_max.sv
// rtl/mem_scan_max.sv - sequential max/min scan over a combinational-read memory
module mem_scan_max #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  mem_data,
    output logic [ADDR_W-1:0] mem_adrs,
    output logic              mem_rw,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  max_val,
    output logic [ADDR_W-1:0] max_adrs,
    output logic [ADDR_W:0]   max_cnt,
    output logic [WIDTH-1:0]  min_val,
    output logic [ADDR_W-1:0] min_adrs
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] DONE_S = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADRS = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] counter;

    logic [WIDTH-1:0]  run_max,      run_min;
    logic [ADDR_W-1:0] run_max_adrs, run_min_adrs;
    logic [ADDR_W:0]   run_cnt;

    logic [WIDTH-1:0]  nxt_max,      nxt_min;
    logic [ADDR_W-1:0] nxt_max_adrs, nxt_min_adrs;
    logic [ADDR_W:0]   nxt_cnt;

    // The first sample seeds the running registers, so no reset value is ever compared.
    always_comb begin
        nxt_max      = run_max;
        nxt_min      = run_min;
        nxt_max_adrs = run_max_adrs;
        nxt_min_adrs = run_min_adrs;
        nxt_cnt      = run_cnt;
        if (counter == '0) begin
            nxt_max      = mem_data;
            nxt_min      = mem_data;
            nxt_max_adrs = counter;
            nxt_min_adrs = counter;
            nxt_cnt      = (ADDR_W+1)'(1);
        end else begin
            if (mem_data > run_max) begin
                nxt_max      = mem_data;
                nxt_max_adrs = counter;
                nxt_cnt      = (ADDR_W+1)'(1);
            end else if (mem_data == run_max) begin
                nxt_max_adrs = counter;
                nxt_cnt      = run_cnt + (ADDR_W+1)'(1);
            end
            if (mem_data <= run_min) begin
                nxt_min      = mem_data;
                nxt_min_adrs = counter;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            run_max      <= '0;
            run_min      <= '0;
            run_max_adrs <= '0;
            run_min_adrs <= '0;
            run_cnt      <= '0;
            done         <= 1'b0;
            max_val      <= '0;
            max_adrs     <= '0;
            max_cnt      <= '0;
            min_val      <= '0;
            min_adrs     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SCAN;
                        counter <= '0;
                    end
                end
                SCAN: begin
                    run_max      <= nxt_max;
                    run_min      <= nxt_min;
                    run_max_adrs <= nxt_max_adrs;
                    run_min_adrs <= nxt_min_adrs;
                    run_cnt      <= nxt_cnt;
                    counter      <= counter + 1'b1;
                    // Results are captured on the edge entering DONE so they are valid during DONE.
                    if (counter == LAST_ADRS) begin
                        state    <= DONE_S;
                        done     <= 1'b1;
                        max_val  <= nxt_max;
                        max_adrs <= nxt_max_adrs;
                        max_cnt  <= nxt_cnt;
                        min_val  <= nxt_min;
                        min_adrs <= nxt_min_adrs;
                    end
                end
                DONE_S: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_adrs = counter;
    assign mem_rw   = 1'b1;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_scan_max.sv
// tb/tb_mem_scan_max.sv - self-checking bench for mem_scan_max
module tb_mem_scan_max;

    typedef struct packed {
        logic [3:0] mv;
        logic [3:0] ma;
        logic [4:0] mc;
        logic [3:0] nv;
        logic [3:0] na;
    } res_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] mem_data;
    logic [3:0] mem_adrs;
    logic       mem_rw;
    logic       busy;
    logic       done;
    logic [3:0] max_val;
    logic [3:0] max_adrs;
    logic [4:0] max_cnt;
    logic [3:0] min_val;
    logic [3:0] min_adrs;

    logic [3:0] mem [16];
    res_t       sb [$];
    int         tests = 0;
    int         fails = 0;

    mem_scan_max #(.DEPTH(16), .WIDTH(4), .ADDR_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mem_data (mem_data),
        .mem_adrs (mem_adrs),
        .mem_rw   (mem_rw),
        .busy     (busy),
        .done     (done),
        .max_val  (max_val),
        .max_adrs (max_adrs),
        .max_cnt  (max_cnt),
        .min_val  (min_val),
        .min_adrs (min_adrs)
    );

    always #5 clk = ~clk;

    assign mem_data = mem[mem_adrs];

    function automatic res_t model();
        res_t r;
        r = '0;
        r.nv = 4'hf;
        for (int i = 0; i < 16; i++) begin
            if (mem[i] > r.mv) r.mv = mem[i];
            if (mem[i] < r.nv) r.nv = mem[i];
        end
        for (int i = 0; i < 16; i++) begin
            if (mem[i] == r.mv) begin
                r.ma = 4'(i);
                r.mc = r.mc + 5'd1;
            end
            if (mem[i] == r.nv) r.na = 4'(i);
        end
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: done=1 with no scan expected");
            end else begin
                res_t e;
                e = sb.pop_front();
                if ({max_val, max_adrs, max_cnt, min_val, min_adrs} !== e) begin
                    fails++;
                    $display("FAIL results: got max=%0d@%0d cnt=%0d min=%0d@%0d, want max=%0d@%0d cnt=%0d min=%0d@%0d",
                             max_val, max_adrs, max_cnt, min_val, min_adrs, e.mv, e.ma, e.mc, e.nv, e.na);
                end
            end
        end
    end

    task automatic run_scan(input res_t e, input string name);
        int k;
        sb.push_back(e);
        start = 1'b1;
        k = -1;
        for (int i = 0; i < 40 && k < 0; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) k = i;
        end
        tests++;
        if (k !== 16) begin
            fails++;
            $display("FAIL %s_latency: done at cycle %0d, want 16", name, k);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle: busy=%b done=%b, want 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, mem_adrs, mem_rw} !== {1'b0, 1'b0, 4'd0, 1'b1}) begin
            fails++;
            $display("FAIL reset_ctrl: busy=%b done=%b adrs=%0d rw=%b, want 0 0 0 1", busy, done, mem_adrs, mem_rw);
        end
        tests++;
        if ({max_val, max_adrs, max_cnt, min_val, min_adrs} !== 21'd0) begin
            fails++;
            $display("FAIL reset_results: got %h, want 0", {max_val, max_adrs, max_cnt, min_val, min_adrs});
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [3:0] v [16] = '{1, 3, 9, 7, 8, 12, 5, 0, 1, 7, 9, 14, 2, 15, 1, 0};
        for (int i = 0; i < 16; i++) mem[i] = v[i];
        run_scan('{mv: 4'd15, ma: 4'd13, mc: 5'd1, nv: 4'd0, na: 4'd15}, "basic");
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        run_scan('{mv: 4'd0, ma: 4'd15, mc: 5'd16, nv: 4'd0, na: 4'd15}, "all_zero");
    endtask

    task automatic test_ties();
        for (int i = 0; i < 16; i++) mem[i] = (i == 2 || i == 7 || i == 11) ? 4'd5 : 4'd4;
        run_scan('{mv: 4'd5, ma: 4'd11, mc: 5'd3, nv: 4'd4, na: 4'd15}, "ties");
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, (n < 2) ? 3 : 15));
            run_scan(model(), "random");
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        for (int i = 0; i < 16; i++) mem[i] = 4'(i + 1);
        sb.push_back(model());
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 7) reset = 1'b1;
        end
        sb.delete();
        @(negedge clk);
        tests++;
        if ({busy, done, mem_adrs} !== 6'd0) begin
            fails++;
            $display("FAIL reset_mid_ctrl: busy=%b done=%b adrs=%0d, want 0 0 0", busy, done, mem_adrs);
        end
        tests++;
        if ({max_val, max_adrs, max_cnt, min_val, min_adrs} !== 21'd0) begin
            fails++;
            $display("FAIL reset_mid_results: got %h, want 0", {max_val, max_adrs, max_cnt, min_val, min_adrs});
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        tests++;
        if (ndone !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_done: got %0d pulses, want 0", ndone);
        end
        run_scan(model(), "after_reset");
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        int first = -1;
        for (int i = 0; i < 16; i++) mem[i] = 4'(15 - i);
        sb.push_back(model());
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = (i == 4);
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = i;
            end
        end
        tests++;
        if (ndone !== 1 || first !== 16) begin
            fails++;
            $display("FAIL start_ignored: %0d pulses first at %0d, want 1 at 16", ndone, first);
        end
    endtask

    task automatic test_back_to_back();
        res_t e;
        for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
        e = model();
        sb.push_back(e);
        sb.push_back(e);
        start = 1'b1;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (i == 34) start = 1'b0;
            tests++;
            if (mem_rw !== 1'b1) begin
                fails++;
                $display("FAIL b2b_rw: cycle %0d got %b, want 1", i, mem_rw);
            end
            if (i <= 15 || (i >= 18 && i <= 33)) begin
                tests++;
                if (mem_adrs !== 4'((i <= 15) ? i : i - 18)) begin
                    fails++;
                    $display("FAIL b2b_adrs: cycle %0d got %0d, want %0d", i, mem_adrs, (i <= 15) ? i : i - 18);
                end
            end
            tests++;
            if (done !== ((i == 16 || i == 34) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL b2b_done: cycle %0d got %b", i, done);
            end
            if (i >= 17 && i <= 33) begin
                tests++;
                if ({max_val, max_adrs, max_cnt, min_val, min_adrs} !== e) begin
                    fails++;
                    $display("FAIL b2b_stable: cycle %0d got %h, want %h", i, {max_val, max_adrs, max_cnt, min_val, min_adrs}, e);
                end
            end
        end
        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL b2b_pending: %0d scans never completed", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_basic();
        test_all_zero();
        test_ties();
        test_random();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
